piso_serializer: RTL and testbench
==================================

# piso_serializer

Parametrised parallel-in/serial-out shifter with a valid/ready load handshake, selectable bit order and a per-bit shift enable. It accepts a WIDTH-bit word, presents it one bit per enabled cycle on qout/qbar, and flags frame completion. It is the generalised successor of the team's fixed 4-bit load/shift PISO and drives serial links and bit-banged peripherals from a parallel datapath.

## Interface
- WIDTH, 8, data word width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word; sampled only on an accept.
- load_valid  input  1  producer has a word on din.
- load_ready  output  1  block can accept a word this cycle.
- lsb_first  input  1  1 = din[0] first, 0 = din[WIDTH-1] first; sampled only on an accept.
- ser_en  input  1  shift tick; advances to the next bit; ignored in IDLE.
- qout  output  1  serial data, registered.
- qbar  output  1  always ~qout.
- busy  output  1  frame in progress (state != IDLE).
- frame_done  output  1  one-cycle pulse after the last bit of a frame is consumed.

## Operation
- States: IDLE, SHIFT, and PARITY (PARITY exists only when PISO_PARITY_EN is defined).
- Internal state: WIDTH-bit shift register, $clog2(WIDTH)-bit bit counter cnt, latched order flag.
- Accept = load_valid && load_ready, evaluated at the rising edge.
- IDLE:
  - load_ready = 1; qout = 0; ser_en ignored.
  - On accept: load din, latch lsb_first, set cnt = 0, drive qout with the first bit, go to SHIFT.
- SHIFT, ser_en = 1, cnt < WIDTH-1: shift register moves one position in the latched direction; qout takes the next bit; cnt increments.
- SHIFT, ser_en = 1, cnt = WIDTH-1 (last bit):
  - Parity off: frame ends.
  - Parity on: go to PARITY; qout takes the parity bit.
- PARITY, ser_en = 1: frame ends.
- ser_en = 0 in SHIFT or PARITY: everything holds, including qout.
- Frame end:
  - frame_done pulses high the next cycle.
  - If an accept occurs on the same edge, load the new word exactly as from IDLE and go to SHIFT, with no idle bit between frames.
  - Otherwise go to IDLE; qout = 0.
- load_ready is combinational: 1 in IDLE, and 1 in the last-bit state when ser_en = 1. It is 0 in every other cycle.
- load_valid while load_ready = 0 is ignored; the producer must hold din stable until accepted.

## Timing
- Reset (rst = 0): qout = 0, qbar = 1, busy = 0, frame_done = 0, state IDLE, shift register and cnt cleared. load_ready reads 1 once in IDLE.
- Reset mid-frame aborts the frame immediately. No frame_done is produced and the partial word is discarded.
- Latency: accept at edge N puts the first bit on qout after edge N.
- With ser_en held high, bit i is on qout during cycle N+i.
- Frame length: WIDTH bits, or WIDTH+1 with parity.
- frame_done is high for the one cycle after the edge that consumes the final bit. It coincides with the first bit of a back-to-back frame when one is accepted on that edge.
- qbar is derived from the registered qout and has zero added latency.

## Configuration
- Macro: PISO_PARITY_EN.
- Defined: PARITY state is built. After the data bits, one even-parity bit (XOR of the accepted word) is sent, and frame_done follows that bit.
- Undefined: no PARITY state and no parity logic. The frame is exactly WIDTH bits.

## Test plan
- Reset: assert rst = 0 mid-frame -> qout = 0, qbar = 1, busy = 0, load_ready = 1 immediately; no frame_done.
- MSB-first, WIDTH=8, din = 8'hA5, lsb_first = 0, ser_en high -> qout sequence 1,0,1,0,0,1,0,1; busy for 8 cycles; single frame_done pulse.
- LSB-first with gaps, din = 8'h3C, lsb_first = 1, ser_en toggling 1,0,1,0… -> qout sequence 0,0,1,1,1,1,0,0, each bit held through the ser_en = 0 cycles.
- Back-to-back: 8'hFF then 8'h00, load_valid held, ser_en high -> 16 contiguous bits with no idle gap; load_ready high only on the last-bit cycles; two frame_done pulses.
- Handshake: load_valid asserted mid-frame with a changing din -> ignored until load_ready; the word accepted is din at the accept edge.
- Parity (PISO_PARITY_EN defined), din = 8'h07, MSB-first -> 0,0,0,0,0,1,1,1, then parity 1; frame_done after the 9th bit.

Source files
------------

// File: rtl/piso_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer_if
//  Description : Bundle of load handshake, shift control and serial outputs
//                for piso_serializer.
//                master : producer / consumer side (drives din, load_valid,
//                         lsb_first, ser_en; observes the rest)
//                slave  : the serializer itself
//  Signals     : din[WIDTH-1:0] parallel word, load_valid / load_ready
//                handshake, lsb_first bit order, ser_en shift tick,
//                qout / qbar serial data, busy, frame_done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
interface piso_serializer_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             lsb_first;
    logic             ser_en;
    logic             qout;
    logic             qbar;
    logic             busy;
    logic             frame_done;

    modport master (
        output din, load_valid, lsb_first, ser_en,
        input  load_ready, qout, qbar, busy, frame_done
    );

    modport slave (
        input  din, load_valid, lsb_first, ser_en,
        output load_ready, qout, qbar, busy, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parametrised parallel-in/serial-out shifter. Accepts a
//                WIDTH-bit word over a valid/ready handshake, then emits one
//                bit per ser_en tick on the registered qout (qbar = ~qout),
//                MSB- or LSB-first as latched at accept time. frame_done
//                pulses for one cycle after the last bit is consumed; a new
//                word may be accepted on that same edge with no idle gap.
//  Ports       : clk            rising-edge clock
//                rst            asynchronous, active-low reset
//                bus (slave)    din, load_valid, load_ready, lsb_first,
//                               ser_en, qout, qbar, busy, frame_done
//  Options     : PISO_PARITY_EN - when defined, an even-parity bit (XOR of
//                the accepted word) follows the data bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    piso_serializer_if.slave    bus
);

    localparam int                c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1
`ifdef PISO_PARITY_EN
        ,
        ST_PARITY = 2'd2
`endif
    } state_t;

    state_t             r_state;
    state_t             w_state_n;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   w_shreg_n;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_n;
    logic               r_lsb;
    logic               w_lsb_n;
    logic               r_qout;
    logic               w_qout_n;
    logic               r_done;
    logic               w_done_n;
`ifdef PISO_PARITY_EN
    logic               r_par;
    logic               w_par_n;
`endif

    logic               w_last_state;
    logic               w_load_ready;
    logic               w_accept;
    logic               w_frame_end;
    logic [WIDTH-1:0]   w_shifted;

    // The state holding the final bit of a frame: that is where a new word
    // can be taken on the consuming edge, giving gapless back-to-back frames.
`ifdef PISO_PARITY_EN
    assign w_last_state = (r_state == ST_PARITY);
`else
    assign w_last_state = (r_state == ST_SHIFT) && (r_cnt == c_last);
`endif

    assign w_load_ready = (r_state == ST_IDLE) || (w_last_state && bus.ser_en);
    assign w_accept     = bus.load_valid && w_load_ready;

    // The bit currently on qout sits at the outgoing end of the register;
    // shifting toward that end exposes the next bit.
    assign w_shifted    = r_lsb ? (r_shreg >> 1) : (r_shreg << 1);

    always_comb begin
        w_state_n   = r_state;
        w_shreg_n   = r_shreg;
        w_cnt_n     = r_cnt;
        w_lsb_n     = r_lsb;
        w_qout_n    = r_qout;
        w_done_n    = 1'b0;
        w_frame_end = 1'b0;
`ifdef PISO_PARITY_EN
        w_par_n     = r_par;
`endif

        case (r_state)
            ST_IDLE: begin
                w_qout_n = 1'b0;
            end
            ST_SHIFT: begin
                if (bus.ser_en) begin
                    if (r_cnt == c_last) begin
`ifdef PISO_PARITY_EN
                        w_state_n = ST_PARITY;
                        w_qout_n  = r_par;
`else
                        w_frame_end = 1'b1;
`endif
                    end else begin
                        w_shreg_n = w_shifted;
                        w_qout_n  = r_lsb ? w_shifted[0] : w_shifted[WIDTH-1];
                        w_cnt_n   = r_cnt + c_one;
                    end
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                if (bus.ser_en) begin
                    w_frame_end = 1'b1;
                end
            end
`endif
            default: begin
                w_state_n = ST_IDLE;
                w_qout_n  = 1'b0;
            end
        endcase

        if (w_frame_end) begin
            w_done_n  = 1'b1;
            w_state_n = ST_IDLE;
            w_qout_n  = 1'b0;
            w_cnt_n   = '0;
        end

        // An accept (from IDLE or on the frame-ending edge) overrides the
        // return to IDLE and starts the next frame with its first bit.
        if (w_accept) begin
            w_state_n = ST_SHIFT;
            w_shreg_n = bus.din;
            w_lsb_n   = bus.lsb_first;
            w_cnt_n   = '0;
            w_qout_n  = bus.lsb_first ? bus.din[0] : bus.din[WIDTH-1];
`ifdef PISO_PARITY_EN
            w_par_n   = ^bus.din;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_lsb   <= 1'b0;
            r_qout  <= 1'b0;
            r_done  <= 1'b0;
`ifdef PISO_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_n;
            r_shreg <= w_shreg_n;
            r_cnt   <= w_cnt_n;
            r_lsb   <= w_lsb_n;
            r_qout  <= w_qout_n;
            r_done  <= w_done_n;
`ifdef PISO_PARITY_EN
            r_par   <= w_par_n;
`endif
        end
    end

    assign bus.load_ready = w_load_ready;
    assign bus.qout       = r_qout;
    assign bus.qbar       = ~r_qout;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_serializer
//  Description : Directed self-checking bench for piso_serializer (WIDTH=8).
//                Expected serial sequences are hand-computed and stored as
//                9-bit vectors: 8 data bits in transmit order, then parity.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
    localparam int c_par = 1;
`else
    localparam int c_par = 0;
`endif
    localparam int c_fl = 8 + c_par;

    logic clk = 1'b0;
    logic rst;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(8)) bus ();

    piso_serializer #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst            = 1'b0;
        bus.din        = 8'h00;
        bus.load_valid = 1'b0;
        bus.lsb_first  = 1'b0;
        bus.ser_en     = 1'b0;
        tick();
        vec_cnt++;
        if (bus.qout !== 1'b0 || bus.qbar !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_q: qout=%b qbar=%b want 0/1", bus.qout, bus.qbar);
        end
        vec_cnt++;
        if (bus.busy !== 1'b0 || bus.frame_done !== 1'b0 || bus.load_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_ctl: busy=%b done=%b ready=%b want 0/0/1",
                     bus.busy, bus.frame_done, bus.load_ready);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_msb_first();
        logic [8:0] seq = 9'b10100101_0;   // 8'hA5 MSB first, parity 0
        bus.din        = 8'hA5;
        bus.lsb_first  = 1'b0;
        bus.ser_en     = 1'b1;
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        bus.din        = 8'h00;
        for (int i = 0; i < c_fl; i++) begin
            vec_cnt++;
            if (bus.qout !== seq[8-i] || bus.qbar !== ~seq[8-i]) begin
                err_cnt++;
                $display("FAIL msb_bit%0d: qout=%b qbar=%b want qout=%b", i, bus.qout, bus.qbar, seq[8-i]);
            end
            vec_cnt++;
            if (bus.busy !== 1'b1 || bus.frame_done !== 1'b0 || bus.load_ready !== (i == c_fl - 1)) begin
                err_cnt++;
                $display("FAIL msb_ctl%0d: busy=%b done=%b ready=%b want 1/0/%b",
                         i, bus.busy, bus.frame_done, bus.load_ready, (i == c_fl - 1));
            end
            tick();
        end
        vec_cnt++;
        if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0 || bus.qout !== 1'b0) begin
            err_cnt++;
            $display("FAIL msb_end: done=%b busy=%b qout=%b want 1/0/0", bus.frame_done, bus.busy, bus.qout);
        end
        tick();
        vec_cnt++;
        if (bus.frame_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL msb_pulse: done=%b want 0", bus.frame_done);
        end
    endtask

    task automatic test_lsb_gaps();
        logic [8:0] seq = 9'b00111100_0;   // 8'h3C LSB first, parity 0
        bus.din        = 8'h3C;
        bus.lsb_first  = 1'b1;
        bus.ser_en     = 1'b0;
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        bus.lsb_first  = 1'b0;
        bus.din        = 8'hFF;
        for (int i = 0; i < c_fl; i++) begin
            bus.ser_en = 1'b0;
            #1;
            vec_cnt++;
            if (bus.qout !== seq[8-i] || bus.load_ready !== 1'b0) begin
                err_cnt++;
                $display("FAIL lsb_bit%0d: qout=%b ready=%b want %b/0", i, bus.qout, bus.load_ready, seq[8-i]);
            end
            tick();
            vec_cnt++;
            if (bus.qout !== seq[8-i] || bus.busy !== 1'b1) begin
                err_cnt++;
                $display("FAIL lsb_hold%0d: qout=%b busy=%b want %b/1", i, bus.qout, bus.busy, seq[8-i]);
            end
            bus.ser_en = 1'b1;
            #1;
            vec_cnt++;
            if (bus.load_ready !== (i == c_fl - 1)) begin
                err_cnt++;
                $display("FAIL lsb_ready%0d: ready=%b want %b", i, bus.load_ready, (i == c_fl - 1));
            end
            tick();
        end
        vec_cnt++;
        if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL lsb_end: done=%b busy=%b want 1/0", bus.frame_done, bus.busy);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int     pulses = 0;
        logic   exp_q;
        bus.din        = 8'hFF;
        bus.lsb_first  = 1'b0;
        bus.ser_en     = 1'b1;
        bus.load_valid = 1'b1;
        tick();
        bus.din = 8'h00;
        for (int k = 0; k < 2 * c_fl; k++) begin
            exp_q = (k < 8);
            vec_cnt++;
            if (bus.qout !== exp_q || bus.busy !== 1'b1) begin
                err_cnt++;
                $display("FAIL b2b_bit%0d: qout=%b busy=%b want %b/1", k, bus.qout, bus.busy, exp_q);
            end
            vec_cnt++;
            if (bus.load_ready !== ((k % c_fl) == c_fl - 1) || bus.frame_done !== (k == c_fl)) begin
                err_cnt++;
                $display("FAIL b2b_ctl%0d: ready=%b done=%b want %b/%b", k, bus.load_ready,
                         bus.frame_done, ((k % c_fl) == c_fl - 1), (k == c_fl));
            end
            if (bus.frame_done === 1'b1) pulses++;
            if (k == c_fl) bus.load_valid = 1'b0;
            tick();
        end
        if (bus.frame_done === 1'b1) pulses++;
        vec_cnt++;
        if (pulses !== 2 || bus.busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_end: pulses=%0d busy=%b want 2/0", pulses, bus.busy);
        end
        tick();
    endtask

    task automatic test_handshake();
        logic [8:0] seq1 = 9'b10000001_0;  // 8'h81 MSB first, parity 0
        logic [8:0] seq2 = 9'b01011010_0;  // 8'h5A MSB first, parity 0
        bus.din        = 8'h81;
        bus.lsb_first  = 1'b0;
        bus.ser_en     = 1'b1;
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        for (int i = 0; i < c_fl; i++) begin
            vec_cnt++;
            if (bus.qout !== seq1[8-i]) begin
                err_cnt++;
                $display("FAIL hs_first%0d: qout=%b want %b", i, bus.qout, seq1[8-i]);
            end
            if (i >= 2) begin
                bus.load_valid = 1'b1;
                bus.din        = (i == c_fl - 1) ? 8'h5A : 8'(8'h10 + i);
            end
            #1;
            vec_cnt++;
            if (bus.load_ready !== (i == c_fl - 1)) begin
                err_cnt++;
                $display("FAIL hs_ready%0d: ready=%b want %b", i, bus.load_ready, (i == c_fl - 1));
            end
            tick();
        end
        bus.load_valid = 1'b0;
        bus.din        = 8'hFF;
        for (int j = 0; j < c_fl; j++) begin
            vec_cnt++;
            if (bus.qout !== seq2[8-j] || bus.frame_done !== (j == 0)) begin
                err_cnt++;
                $display("FAIL hs_second%0d: qout=%b done=%b want %b/%b", j, bus.qout,
                         bus.frame_done, seq2[8-j], (j == 0));
            end
            tick();
        end
        vec_cnt++;
        if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL hs_end: done=%b busy=%b want 1/0", bus.frame_done, bus.busy);
        end
        tick();
    endtask

`ifdef PISO_PARITY_EN
    task automatic test_parity();
        logic [8:0] seq = 9'b00000111_1;   // 8'h07 MSB first, parity 1
        bus.din        = 8'h07;
        bus.lsb_first  = 1'b0;
        bus.ser_en     = 1'b1;
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            vec_cnt++;
            if (bus.qout !== seq[8-i] || bus.load_ready !== (i == 8) || bus.frame_done !== 1'b0) begin
                err_cnt++;
                $display("FAIL par_bit%0d: qout=%b ready=%b done=%b want %b/%b/0", i, bus.qout,
                         bus.load_ready, bus.frame_done, seq[8-i], (i == 8));
            end
            tick();
        end
        vec_cnt++;
        if (bus.frame_done !== 1'b1 || bus.busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL par_end: done=%b busy=%b want 1/0", bus.frame_done, bus.busy);
        end
        tick();
    endtask
`endif

    task automatic test_reset_mid_frame();
        bus.din        = 8'hA5;
        bus.lsb_first  = 1'b0;
        bus.ser_en     = 1'b1;
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        tick();
        tick();
        vec_cnt++;
        if (bus.qout !== 1'b1 || bus.busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL rstmid_pre: qout=%b busy=%b want 1/1", bus.qout, bus.busy);
        end
        rst = 1'b0;
        #1;
        vec_cnt++;
        if (bus.qout !== 1'b0 || bus.qbar !== 1'b1 || bus.busy !== 1'b0 ||
            bus.load_ready !== 1'b1 || bus.frame_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL rstmid_async: qout=%b qbar=%b busy=%b ready=%b done=%b want 0/1/0/1/0",
                     bus.qout, bus.qbar, bus.busy, bus.load_ready, bus.frame_done);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < c_fl + 2; i++) begin
            tick();
            vec_cnt++;
            if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0 || bus.qout !== 1'b0) begin
                err_cnt++;
                $display("FAIL rstmid_after%0d: done=%b busy=%b qout=%b want 0/0/0",
                         i, bus.frame_done, bus.busy, bus.qout);
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_gaps();
        test_back_to_back();
        test_handshake();
`ifdef PISO_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, limit 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
